// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that free-runs every cycle out of reset.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;

  // An all-zero seed would lock the register, so it is swapped for the default.
  always_comb begin
    seed_eff = seed;
    if (seed == '0) seed_eff = DEFAULT_SEED;
  end

  // Advance unconditionally; the state can never reach zero from a non-zero seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed_eff;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical switch: on each level change it emits
// 2*BOUNCE_PAIRS+1 toggles at pseudo-random gaps, then holds the final level.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned BOUNCE_PAIRS  = 3,
  parameter int unsigned MIN_GAP       = 16,
  parameter int unsigned GAP_W         = 10,
  parameter int unsigned SETTLE_CYCLES = 8192,
  parameter logic [15:0] SEED          = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic button_out,
  output logic busy,
  output logic done
);

  localparam logic [4:0]  TOG_LOAD    = 5'(2 * BOUNCE_PAIRS);
  localparam logic [20:0] SETTLE_LOAD = 21'(SETTLE_CYCLES);
  localparam logic [16:0] GAP_BASE    = 17'(MIN_GAP);
  localparam logic [15:0] GAP_MASK    = 16'((32'd1 << GAP_W) - 32'd1);

  state_t      state;
  logic [4:0]  tog_cnt;
  logic [16:0] gap_cnt;
  logic [20:0] settle_cnt;
  logic [15:0] lfsr_q;
  logic [16:0] gap_next;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  // Next gap: minimum spacing plus the low GAP_W LFSR bits, in 17 bits so it never wraps.
  always_comb begin
    gap_next = GAP_BASE + {1'b0, lfsr_q & GAP_MASK};
  end

  // Sequencer: accept in IDLE, toggle through BOUNCE, hold in SETTLE, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      button_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
      tog_cnt    <= '0;
      gap_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_level == button_out) begin
              done <= 1'b1;
            end else begin
              button_out <= ~button_out;
              tog_cnt    <= TOG_LOAD;
              gap_cnt    <= gap_next;
              state      <= BOUNCE;
              busy       <= 1'b1;
              cmd_ready  <= 1'b0;
            end
          end
        end
        BOUNCE: begin
          if (gap_cnt <= 17'd1) begin
            if (tog_cnt != '0) begin
              button_out <= ~button_out;
              tog_cnt    <= tog_cnt - 5'd1;
              gap_cnt    <= gap_next;
            end else begin
              gap_cnt    <= '0;
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 17'd1;
          end
        end
        SETTLE: begin
          if (settle_cnt <= 21'd1) begin
            settle_cnt <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
            done       <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 21'd1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: command table plus scoreboard of predicted events.
module tb_bounce_gen;

  localparam int BP = 3;
  localparam int MG = 16;
  localparam int GW = 10;
  localparam int SC = 8192;
  localparam logic [15:0] GMASK = 16'h03FF;
  localparam int EV_TOG  = 0;
  localparam int EV_DONE = 1;

  typedef struct {
    int   kind;
    int   off;
    logic lvl;
  } ev_t;

  typedef struct {
    logic lvl;
    logic noisy;
    logic exp_busy;
    logic exp_ready;
    int   exp_pulses;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_level, cmd_ready, button_out, busy, done;
  logic s_valid, s_level, s_ready, s_button, s_busy, s_done;

  bounce_gen u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_level(cmd_level),
    .cmd_ready(cmd_ready), .button_out(button_out), .busy(busy), .done(done)
  );

  bounce_gen #(.BOUNCE_PAIRS(0), .MIN_GAP(4), .GAP_W(1), .SETTLE_CYCLES(6)) u_small (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_valid), .cmd_level(s_level),
    .cmd_ready(s_ready), .button_out(s_button), .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_tog = 0;
  logic have_last = 1'b0;
  logic prev_btn = 1'b0;
  logic model_level = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  ev_t sbq[$];
  int run_offs[$];
  int db_cnt = 0;
  int db_pulses = 0;
  logic db_lvl = 1'b0;
  logic db_last = 1'b0;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lstep(m_lfsr);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic take(input int kind, input int off, input logic lv);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: kind %0d offset %0d lvl %0d, nothing expected", kind, off, lv);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.off != off || e.lvl != lv) begin
        errors++;
        $display("FAIL sb_event: got kind %0d off %0d lvl %0d expected kind %0d off %0d lvl %0d",
                 kind, off, lv, e.kind, e.off, e.lvl);
      end
    end
  endtask

  // Predict every toggle and the done pulse of one command, as offsets from the accept edge.
  task automatic predict(input logic lvl, input logic cur, input logic [15:0] l0);
    ev_t e;
    int o, g;
    logic lv;
    logic [15:0] l;
    l = l0; o = 0; lv = cur;
    if (lvl == cur) begin
      e = '{kind: EV_DONE, off: 0, lvl: cur};
      sbq.push_back(e);
      return;
    end
    for (int k = 0; k < 2 * BP + 1; k++) begin
      lv = ~lv;
      e = '{kind: EV_TOG, off: o, lvl: lv};
      sbq.push_back(e);
      g = MG + int'(l & GMASK);
      for (int s = 0; s < g; s++) l = lstep(l);
      o += g;
    end
    e = '{kind: EV_DONE, off: o + SC, lvl: lv};
    sbq.push_back(e);
  endtask

  // Monitor: observe DUT events away from the clock edge and score them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_btn = button_out;
    end else begin
      if (button_out !== prev_btn) begin
        take(EV_TOG, cyc - acc_cyc, button_out);
        run_offs.push_back(cyc - acc_cyc);
        if (have_last) begin
          checks++;
          if (cyc - last_tog < MG || cyc - last_tog > MG + (1 << GW) - 1) begin
            errors++;
            $display("FAIL gap_range: got %0d required %0d..%0d", cyc - last_tog, MG, MG + (1 << GW) - 1);
          end
        end
        have_last = 1'b1;
        last_tog = cyc;
      end
      if (done) take(EV_DONE, cyc - acc_cyc, button_out);
      prev_btn = button_out;
    end
  end

  // Behavioural debouncer: 8191-cycle stability, counts press (0->1) pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      db_cnt = 0; db_lvl = 1'b0; db_last = 1'b0;
    end else begin
      if (button_out !== db_last) db_cnt = 0;
      else if (db_cnt < 8191) db_cnt++;
      db_last = button_out;
      if (db_cnt == 8191 && db_lvl != button_out) begin
        db_lvl = button_out;
        if (button_out) db_pulses++;
      end
    end
  end

  task automatic issue(input logic lvl, input logic noisy, input logic exp_busy, input logic exp_ready);
    @(posedge clk); #2;
    have_last = 1'b0;
    run_offs.delete();
    predict(lvl, model_level, m_lfsr);
    acc_cyc = cyc + 1;
    model_level = lvl;
    cmd_valid = 1'b1;
    cmd_level = lvl;
    @(posedge clk); #2;
    chk("accept_busy", busy, exp_busy);
    chk("accept_ready", cmd_ready, exp_ready);
    if (noisy) begin
      for (int n = 0; n < 300; n++) begin
        cmd_level = ~cmd_level;
        @(posedge clk); #2;
      end
      chk("noisy_ready_low", cmd_ready, 0);
      chk("noisy_busy_high", busy, 1);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk("sb_drained", sbq.size(), 0);
    @(posedge clk); #2;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_button_async", button_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_done", done, 0);
    sbq.delete();
    model_level = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  vec_t tbl[4];
  int first_offs[3];
  int sg, sa, soff, sflips, sready_at_done, n;
  logic got;

  initial begin
    tbl[0] = '{lvl: 1'b1, noisy: 1'b0, exp_busy: 1'b1, exp_ready: 1'b0, exp_pulses: 1};
    tbl[1] = '{lvl: 1'b1, noisy: 1'b0, exp_busy: 1'b0, exp_ready: 1'b1, exp_pulses: 1};
    tbl[2] = '{lvl: 1'b0, noisy: 1'b1, exp_busy: 1'b1, exp_ready: 1'b0, exp_pulses: 1};
    tbl[3] = '{lvl: 1'b0, noisy: 1'b0, exp_busy: 1'b0, exp_ready: 1'b1, exp_pulses: 1};
    cmd_valid = 1'b0; cmd_level = 1'b0; s_valid = 1'b0; s_level = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_button", button_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_small_ready", s_ready, 1);
    rst_n = 1'b1;

    // Zero bounce pairs: one toggle, one gap of 4 or 5, then a 6-cycle settle.
    @(posedge clk); #2;
    sg = 4 + int'(m_lfsr[0]);
    sa = cyc + 1;
    s_valid = 1'b1; s_level = 1'b1;
    @(posedge clk); #2;
    s_valid = 1'b0;
    chk("small_toggle", s_button, 1);
    chk("small_busy", s_busy, 1);
    chk("small_ready", s_ready, 0);
    sflips = 0; got = 1'b0; soff = -1; sready_at_done = 0; n = 0;
    while (!got && n < 100) begin
      @(posedge clk); #2;
      n++;
      if (s_button !== 1'b1) sflips++;
      if (s_done) begin
        got = 1'b1;
        soff = cyc - sa;
        sready_at_done = s_ready;
      end
    end
    chk("small_done_seen", got, 1);
    chk("small_done_offset", soff, sg + 6);
    chk("small_held", sflips, 0);
    chk("small_ready_with_done", sready_at_done, 1);
    @(posedge clk); #2;
    chk("small_done_width", s_done, 0);

    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].lvl, tbl[i].noisy, tbl[i].exp_busy, tbl[i].exp_ready);
      wait_empty(20000);
      chk("final_level", button_out, tbl[i].lvl);
      chk("idle_ready", cmd_ready, 1);
      chk("debounce_pulses", db_pulses, tbl[i].exp_pulses);
    end

    // Reset mid-bounce must abort cleanly and restart the gap sequence exactly.
    pulse_reset();
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (run_offs.size() < 3 && n < 5000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("run1_toggles", run_offs.size() >= 3, 1);
    for (int k = 0; k < 3; k++) first_offs[k] = (k < run_offs.size()) ? run_offs[k] : -1;
    pulse_reset();
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    wait_empty(20000);
    chk("run2_toggles", run_offs.size(), 2 * BP + 1);
    for (int k = 0; k < 3; k++)
      chk("repeat_offset", (k < run_offs.size()) ? run_offs[k] : -2, first_offs[k]);
    chk("run2_final", button_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
